// File: rtl/ex_muldiv.sv
// Iterative unsigned multiply/divide unit for the EX stage.
// One shift-add or restoring-divide iteration per cycle; stalls the pipeline while busy.
module ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            stall_o,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] acc;    // hi (multiply) or remainder (divide)
    logic [XLEN-1:0] lo;     // lo (multiply) or quotient (divide)
    logic [XLEN-1:0] mcand;  // multiplicand or divisor

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   div_trial;
    logic [XLEN-1:0] acc_step;
    logic [XLEN-1:0] lo_step;
    logic [XLEN-1:0] step_res;
    logic            accept;
    logic            div_zero;
    logic            last;

    always_comb begin
        accept    = start & ~flush;
        div_zero  = op[1] & (b == '0);
        last      = (cnt == CW'(XLEN - 1));

        mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
        rem_sh    = {acc, lo[XLEN-1]};
        div_trial = rem_sh - {1'b0, mcand};

        // MSB of the XLEN+1-bit trial is the borrow: set means restore
        if (op_q[1]) begin
            if (!div_trial[XLEN]) begin
                acc_step = div_trial[XLEN-1:0];
                lo_step  = {lo[XLEN-2:0], 1'b1};
            end else begin
                acc_step = rem_sh[XLEN-1:0];
                lo_step  = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_step = mul_sum[XLEN:1];
            lo_step  = {mul_sum[0], lo[XLEN-1:1]};
        end

        // MUL/DIVU take the low/quotient half, MULHU/REMU the high/remainder half
        step_res = op_q[0] ? acc_step : lo_step;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (accept) state_n = div_zero ? S_DONE : S_RUN;
            S_RUN:  if (last)   state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush) state_n = S_IDLE;

        stall_o = ((state == S_IDLE) & accept) | (state == S_RUN);
        done    = (state == S_DONE) & ~flush;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            rd_q   <= '0;
            acc    <= '0;
            lo     <= '0;
            mcand  <= '0;
            result <= '0;
            rd_out <= '0;
        end else begin
            state <= state_n;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        rd_q  <= rd_in;
                        cnt   <= '0;
                        acc   <= '0;
                        lo    <= op[1] ? a : b;
                        mcand <= op[1] ? b : a;
                        if (div_zero) begin
                            result <= op[0] ? a : '1;
                            rd_out <= rd_in;
                        end
                    end
                end
                S_RUN: begin
                    if (!flush) begin
                        acc <= acc_step;
                        lo  <= lo_step;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            result <= step_res;
                            rd_out <= rd_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
